pic_core_param: RTL and testbench
=================================

PIC_CORE_PARAM -- requirements
Module: pic_core_param

Interface
REQ-001 Parameters: DATA_W (default 8) sets the W/ALU width and SHALL be >= 8; ADDR_W (default 11) sets the program-counter and instruction-address width; STK_DEPTH (default 8) sets the call-stack entry count and SHALL be >= 2.
REQ-002 Ports:
- clk, input, 1: sole clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- run, input, 1: enables instruction fetch.
- imem_addr, output, ADDR_W: instruction address, driven from the internal MAR.
- imem_data, input, 14: instruction word; combinational memory, valid one cycle after imem_addr changes.
- w_q, output, DATA_W: working register.
- z_flag, output, 1: zero flag.
- c_flag, output, 1: carry / no-borrow flag.
- pc_q, output, ADDR_W: program counter.
- instr_done, output, 1: one-cycle pulse in the EXEC cycle.
- stk_ovf, output, 1: sticky stack-overflow flag.
- stk_unf, output, 1: sticky stack-underflow flag.

Function
REQ-003 The FSM SHALL have the states IDLE, MAR, INC, LOAD and EXEC.
- IDLE: IR cleared to 0; go to MAR if run=1, else stay in IDLE.
- MAR: MAR <= PC; go to INC.
- INC: PC <= PC+1, wrapping modulo 2^ADDR_W; go to LOAD.
- LOAD: IR <= imem_data; go to EXEC.
- EXEC: perform the operation; go to MAR if run=1, else IDLE.
REQ-004 One instruction SHALL take exactly 4 cycles (MAR, INC, LOAD, EXEC) while run stays 1; instr_done SHALL be 1 only in EXEC.
REQ-005 run SHALL be sampled only in IDLE and EXEC; deasserting run mid-instruction SHALL NOT abort that instruction.
REQ-006 Literal k = IR[7:0], zero-extended to DATA_W. Opcode = IR[13:8]. All W results are truncated to DATA_W.
REQ-007 Literal operations, each writing W in EXEC:
- 0x30 movlw: W=k; flags unchanged.
- 0x3E addlw: W=k+W; C=carry out of bit DATA_W-1; Z=(result==0).
- 0x3C sublw: W=k-W; C=1 iff k>=W (unsigned); Z=(result==0).
- 0x39 andlw: W=k&W; Z updated; C unchanged.
- 0x38 iorlw: W=k|W; Z updated; C unchanged.
- 0x3A xorlw: W=k^W; Z updated; C unchanged.
REQ-008 IR[13:11]=3'b101 (goto): PC <= IR[10:0], zero-extended or truncated to ADDR_W; W and flags unchanged.
REQ-009 IR[13:11]=3'b100 (call): push the current PC (already incremented) onto the stack, then PC <= IR[10:0] resized to ADDR_W.
REQ-010 Opcode 0x34 (retlw): W=k; pop the stack into PC; flags unchanged.
REQ-011 Any other IR value, including 0x0000, SHALL be a NOP: only PC advances.
REQ-012 The stack SHALL be a STK_DEPTH-entry LIFO with a pointer/count.
- Push when full: set stk_ovf=1 and overwrite the oldest entry (circular); the count stays at STK_DEPTH.
- Pop when empty: set stk_unf=1; PC is not modified and W is still loaded with k.
- stk_ovf and stk_unf SHALL clear only on reset.
REQ-013 Flags SHALL change only in EXEC, and only per REQ-007.

Reset
REQ-014 With reset=0, asynchronously and independent of clk: state=IDLE; PC, MAR, IR, W, Z, C, stack count, stk_ovf and stk_unf all = 0; instr_done=0; imem_addr=0.
REQ-015 Reset asserted in any state SHALL abandon the current instruction with no partial W, PC or stack update. After release, the first fetch SHALL be from address 0, starting MAR on the first rising edge with run=1.

Verification
REQ-016 Straight-line program with run=1: {0x3005 movlw 5, 0x3E03 addlw 3, 0x3C0A sublw 10, 0x39F0, 0x3A02} -> W after each EXEC is 0x05, 0x08, 0x02, 0x00 (Z=1), 0x02 (Z=0). sublw gives C=1. instr_done pulses every 4th cycle.
REQ-017 Flag boundaries with DATA_W=8: movlw 0xFF then addlw 0x01 -> W=0x00, C=1, Z=1. movlw 0x05 then sublw 0x03 -> W=0xFE, C=0, Z=0.
REQ-018 Control flow: addr0 call 0x010; addr 0x010 retlw 0x7A -> PC=0x010 after the call EXEC. After retlw, W=0x7A and the next fetch is from address 1.
REQ-019 Stack limits with STK_DEPTH=2: a chain of 3 nested calls -> stk_ovf=1 after the 3rd. A retlw with the stack empty -> stk_unf=1, PC continues sequentially, and W=k.
REQ-020 Run and reset control:
- Drop run during INC -> the instruction completes, then the FSM holds in IDLE with PC stable.
- Assert reset mid-LOAD -> all outputs read 0 before the next clk edge.
- PC wrap: with ADDR_W=4, a NOP at address 15 -> the next fetch is from address 0.

Source files
------------

// File: rtl/pic_core_param.sv
// rtl/pic_core_param.sv - parameterised PIC-style core, 4-cycle fetch/execute, literal ALU, goto/call/retlw
// Ports:
//   clk        : clock, all state changes on its rising edge
//   reset      : asynchronous active-low reset
//   run        : enables instruction fetch (sampled in IDLE and EXEC only)
//   imem_addr  : instruction address (MAR)
//   imem_data  : 14-bit instruction word from combinational memory
//   w_q        : working register
//   z_flag     : zero flag
//   c_flag     : carry / no-borrow flag
//   pc_q       : program counter
//   instr_done : high during the EXEC cycle
//   stk_ovf    : sticky call-stack overflow
//   stk_unf    : sticky call-stack underflow
module pic_core_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int STK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [13:0]       imem_data,
  output logic [DATA_W-1:0] w_q,
  output logic              z_flag,
  output logic              c_flag,
  output logic [ADDR_W-1:0] pc_q,
  output logic              instr_done,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int SP_W  = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STK_DEPTH + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAR  = 3'd1;
  localparam logic [2:0] S_INC  = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [13:0]       r_ir;
  logic [DATA_W-1:0] r_w;
  logic              r_z;
  logic              r_c;
  logic              r_ovf;
  logic              r_unf;
  logic [SP_W-1:0]   r_sp;   // next slot to write; top of stack is r_sp-1 (circular)
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_stk [STK_DEPTH];

  logic [DATA_W-1:0] w_k;
  logic [ADDR_W-1:0] w_target;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [SP_W-1:0]   w_sp_inc;
  logic [SP_W-1:0]   w_sp_dec;
  logic              w_stk_full;
  logic              w_stk_empty;

  logic [DATA_W-1:0] w_w_nxt;
  logic              w_z_nxt;
  logic              w_c_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_is_call;
  logic              w_is_ret;

  assign w_k      = DATA_W'(r_ir[7:0]);
  assign w_target = ADDR_W'(r_ir[10:0]);
  assign w_sum    = {1'b0, w_k} + {1'b0, r_w};
  assign w_diff   = {1'b0, w_k} - {1'b0, r_w};

  assign w_sp_inc    = (r_sp == SP_W'(STK_DEPTH - 1)) ? '0 : r_sp + SP_W'(1);
  assign w_sp_dec    = (r_sp == '0) ? SP_W'(STK_DEPTH - 1) : r_sp - SP_W'(1);
  assign w_stk_full  = (r_cnt == CNT_W'(STK_DEPTH));
  assign w_stk_empty = (r_cnt == '0);

  // Execute-stage decode; results are only committed in EXEC.
  always_comb begin
    w_w_nxt   = r_w;
    w_z_nxt   = r_z;
    w_c_nxt   = r_c;
    w_pc_nxt  = r_pc;
    w_is_call = 1'b0;
    w_is_ret  = 1'b0;
    if (r_ir[13:11] == 3'b101) begin
      w_pc_nxt = w_target;
    end else if (r_ir[13:11] == 3'b100) begin
      w_is_call = 1'b1;
      w_pc_nxt  = w_target;
    end else begin
      case (r_ir[13:8])
        6'h30: w_w_nxt = w_k;
        6'h3E: begin
          w_w_nxt = w_sum[DATA_W-1:0];
          w_c_nxt = w_sum[DATA_W];
          w_z_nxt = (w_sum[DATA_W-1:0] == '0);
        end
        6'h3C: begin
          w_w_nxt = w_diff[DATA_W-1:0];
          w_c_nxt = ~w_diff[DATA_W];          // no borrow means k >= W
          w_z_nxt = (w_diff[DATA_W-1:0] == '0);
        end
        6'h39: begin
          w_w_nxt = w_k & r_w;
          w_z_nxt = ((w_k & r_w) == '0);
        end
        6'h38: begin
          w_w_nxt = w_k | r_w;
          w_z_nxt = ((w_k | r_w) == '0);
        end
        6'h3A: begin
          w_w_nxt = w_k ^ r_w;
          w_z_nxt = ((w_k ^ r_w) == '0);
        end
        6'h34: begin
          w_w_nxt  = w_k;
          w_is_ret = 1'b1;
          // An empty pop leaves PC on its already-incremented value.
          if (!w_stk_empty) w_pc_nxt = r_stk[w_sp_dec];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_mar   <= '0;
      r_ir    <= '0;
      r_w     <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_sp    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ir <= '0;
          if (run) r_state <= S_MAR;
        end
        S_MAR: begin
          r_mar   <= r_pc;
          r_state <= S_INC;
        end
        S_INC: begin
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_ir    <= imem_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_w  <= w_w_nxt;
          r_z  <= w_z_nxt;
          r_c  <= w_c_nxt;
          r_pc <= w_pc_nxt;
          if (w_is_call) begin
            r_sp <= w_sp_inc;
            // Full push overwrites the oldest entry; count saturates.
            if (w_stk_full) r_ovf <= 1'b1;
            else            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_is_ret) begin
            if (w_stk_empty) begin
              r_unf <= 1'b1;
            end else begin
              r_sp  <= w_sp_dec;
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          r_state <= run ? S_MAR : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stack storage needs no reset; it is only read when the count says it is valid.
  always_ff @(posedge clk) begin
    if (r_state == S_EXEC && w_is_call) r_stk[r_sp] <= r_pc;
  end

  assign imem_addr  = r_mar;
  assign w_q        = r_w;
  assign z_flag     = r_z;
  assign c_flag     = r_c;
  assign pc_q       = r_pc;
  assign instr_done = (r_state == S_EXEC);
  assign stk_ovf    = r_ovf;
  assign stk_unf    = r_unf;

endmodule

// File: tb/tb_pic_core_param.sv
// tb/tb_pic_core_param.sv - self-checking bench for pic_core_param against an instruction-level model
module tb_pic_core_param;
  localparam int AW    = 11;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          run4 = 1'b0;
  logic [AW-1:0] imem_addr, pc_q;
  logic [13:0]   imem_data;
  logic [7:0]    w_q;
  logic          z_flag, c_flag, instr_done, stk_ovf, stk_unf;
  logic [13:0]   mem [0:2047];

  logic [3:0]    imem_addr4, pc_q4;
  logic [13:0]   imem_data4;
  logic [7:0]    w_q4;
  logic          z4, c4, done4, ovf4, unf4;
  logic [13:0]   mem4 [0:15];

  assign imem_data  = mem[imem_addr];
  assign imem_data4 = mem4[imem_addr4];

  pic_core_param #(.DATA_W(8), .ADDR_W(AW), .STK_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .w_q(w_q), .z_flag(z_flag), .c_flag(c_flag), .pc_q(pc_q), .instr_done(instr_done),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  pic_core_param #(.DATA_W(8), .ADDR_W(4), .STK_DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .reset(reset), .run(run4), .imem_addr(imem_addr4), .imem_data(imem_data4),
    .w_q(w_q4), .z_flag(z4), .c_flag(c4), .pc_q(pc_q4), .instr_done(done4),
    .stk_ovf(ovf4), .stk_unf(unf4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instruction-level reference model
  int   m_w, m_pc;
  bit   m_z, m_c, m_ovf, m_unf;
  int   m_stk[$];

  int            gap;
  bit            got;
  logic [AW-1:0] fetch_addr;

  task automatic model_reset();
    m_w = 0; m_pc = 0; m_z = 0; m_c = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  task automatic model_step();
    logic [13:0] ir;
    int k, t;
    ir = mem[m_pc];
    k  = ir[7:0];
    t  = ir[10:0];
    m_pc = (m_pc + 1) % 2048;
    if (ir[13:11] == 3'b101) begin
      m_pc = t;
    end else if (ir[13:11] == 3'b100) begin
      if (m_stk.size() == DEPTH) begin
        m_ovf = 1;
        void'(m_stk.pop_front());
      end
      m_stk.push_back(m_pc);
      m_pc = t;
    end else begin
      case (ir[13:8])
        6'h30: m_w = k;
        6'h3E: begin t = k + m_w; m_w = t % 256; m_c = (t > 255); m_z = (m_w == 0); end
        6'h3C: begin m_c = (k >= m_w); m_w = (k - m_w + 256) % 256; m_z = (m_w == 0); end
        6'h39: begin m_w = k & m_w; m_z = (m_w == 0); end
        6'h38: begin m_w = k | m_w; m_z = (m_w == 0); end
        6'h3A: begin m_w = k ^ m_w; m_z = (m_w == 0); end
        6'h34: begin
          m_w = k;
          if (m_stk.size() == 0) m_unf = 1;
          else m_pc = m_stk.pop_back();
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [22:0] model_vec();
    logic [7:0]    w8;
    logic [AW-1:0] p;
    w8 = m_w[7:0];
    p  = m_pc[AW-1:0];
    return {w8, m_z, m_c, p, m_ovf, m_unf};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {w_q, z_flag, c_flag, pc_q, stk_ovf, stk_unf};
  endfunction

  // Waits for the next EXEC cycle (bounded), records fetch address and cycles waited, then steps past it.
  task automatic exec_one();
    int n;
    n = 0;
    got = 0;
    while (n < 12) begin
      @(negedge clk);
      if (instr_done === 1'b1) begin
        got = 1;
        break;
      end
      n++;
    end
    gap = n;
    fetch_addr = imem_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 0;
    run4 = 0;
    reset = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 14'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 0;
    run = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({imem_addr, w_q, z_flag, c_flag, pc_q, instr_done, stk_ovf, stk_unf} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0",
               {imem_addr, w_q, z_flag, c_flag, pc_q, instr_done, stk_ovf, stk_unf});
    end
  endtask

  task automatic test_straight();
    logic [7:0] exp_w [5];
    logic       exp_z [5];
    exp_w = '{8'h05, 8'h08, 8'h02, 8'h00, 8'h02};
    exp_z = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    mem[0] = 14'h3005; mem[1] = 14'h3E03; mem[2] = 14'h3C0A; mem[3] = 14'h39F0; mem[4] = 14'h3A02;
    run = 1;
    for (int i = 0; i < 5; i++) begin
      exec_one();
      model_step();
      checks++;
      if (!got || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL straight_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
      checks++;
      if (w_q !== exp_w[i] || z_flag !== exp_z[i] || gap != 3) begin
        errors++;
        $display("FAIL straight_table[%0d]: w=%h z=%b gap=%0d want w=%h z=%b gap=3",
                 i, w_q, z_flag, gap, exp_w[i], exp_z[i]);
      end
      if (i == 2) begin
        checks++;
        if (c_flag !== 1'b1) begin
          errors++;
          $display("FAIL sublw_carry: got %b want 1", c_flag);
        end
      end
    end
  endtask

  task automatic test_flags();
    do_reset();
    mem[0] = 14'h30FF; mem[1] = 14'h3E01; mem[2] = 14'h3005; mem[3] = 14'h3C03;
    run = 1;
    for (int i = 0; i < 4; i++) begin
      exec_one();
      model_step();
      checks++;
      if (!got || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL flags_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i == 1) begin
        checks++;
        if ({w_q, c_flag, z_flag} !== {8'h00, 1'b1, 1'b1}) begin
          errors++;
          $display("FAIL addlw_wrap: got w=%h c=%b z=%b want w=00 c=1 z=1", w_q, c_flag, z_flag);
        end
      end
      if (i == 3) begin
        checks++;
        if ({w_q, c_flag, z_flag} !== {8'hFE, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL sublw_borrow: got w=%h c=%b z=%b want w=fe c=0 z=0", w_q, c_flag, z_flag);
        end
      end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    mem[0] = 14'h2010; mem[11'h010] = 14'h347A;
    run = 1;
    exec_one();
    model_step();
    checks++;
    if (!got || pc_q !== 11'h010 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL call_pc: got %h want %h (pc 010)", dut_vec(), model_vec());
    end
    exec_one();
    model_step();
    checks++;
    if (!got || w_q !== 8'h7A || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL retlw: got %h want %h (w 7a)", dut_vec(), model_vec());
    end
    exec_one();
    model_step();
    checks++;
    if (!got || fetch_addr !== 11'd1) begin
      errors++;
      $display("FAIL ret_fetch: got addr %h want 001", fetch_addr);
    end
  endtask

  task automatic test_stack_limits();
    do_reset();
    mem[0] = 14'h2010; mem[11'h010] = 14'h2020; mem[11'h020] = 14'h2030;
    mem[11'h030] = 14'h3411; mem[11'h021] = 14'h3422; mem[11'h011] = 14'h3433;
    run = 1;
    for (int i = 0; i < 6; i++) begin
      exec_one();
      model_step();
      checks++;
      if (!got || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL stack_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (stk_ovf !== (i == 2)) begin
          errors++;
          $display("FAIL stk_ovf[%0d]: got %b want %b", i, stk_ovf, (i == 2));
        end
      end
    end
    checks++;
    if ({stk_unf, w_q, pc_q} !== {1'b1, 8'h33, 11'h012}) begin
      errors++;
      $display("FAIL underflow: got unf=%b w=%h pc=%h want unf=1 w=33 pc=012", stk_unf, w_q, pc_q);
    end
  endtask

  task automatic test_run_drop();
    int pulses;
    do_reset();
    mem[0] = 14'h3042; mem[1] = 14'h3099;
    run = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    run = 0;
    exec_one();
    model_step();
    checks++;
    if (!got || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL run_drop_exec: got %h want %h", dut_vec(), model_vec());
    end
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (instr_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || pc_q !== 11'd1 || imem_addr !== 11'd0 || w_q !== 8'h42) begin
      errors++;
      $display("FAIL run_drop_idle: pulses=%0d pc=%h addr=%h w=%h want 0 001 000 42",
               pulses, pc_q, imem_addr, w_q);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[0] = 14'h3055; mem[1] = 14'h3E01;
    run = 1;
    exec_one();
    model_step();
    checks++;
    if (!got || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL pre_reset: got %h want %h", dut_vec(), model_vec());
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    checks++;
    if ({imem_addr, w_q, z_flag, c_flag, pc_q, instr_done, stk_ovf, stk_unf} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0",
               {imem_addr, w_q, z_flag, c_flag, pc_q, instr_done, stk_ovf, stk_unf});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    model_reset();
    exec_one();
    model_step();
    checks++;
    if (!got || fetch_addr !== 11'd0 || gap != 3 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL post_reset: addr=%h gap=%0d got %h want addr 000 gap 3 %h",
               fetch_addr, gap, dut_vec(), model_vec());
    end
  endtask

  task automatic test_pc_wrap();
    logic [3:0] addr;
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) mem4[i] = 14'h3000 | 14'(i);
    run4 = 1;
    for (int i = 0; i < 17; i++) begin
      ok = 0;
      for (int n = 0; n < 12; n++) begin
        @(negedge clk);
        if (done4 === 1'b1) begin
          ok = 1;
          break;
        end
      end
      addr = imem_addr4;
      @(posedge clk);
      #1;
      if (i >= 14) begin
        checks++;
        if (!ok || addr !== 4'(i % 16) || w_q4 !== 8'(i % 16) || pc_q4 !== 4'((i + 1) % 16)) begin
          errors++;
          $display("FAIL pc_wrap[%0d]: addr=%h w=%h pc=%h want %h %h %h",
                   i, addr, w_q4, pc_q4, 4'(i % 16), 8'(i % 16), 4'((i + 1) % 16));
        end
      end
    end
    run4 = 0;
  endtask

  task automatic test_random();
    int sel;
    logic [13:0] ops [8];
    ops = '{14'h3000, 14'h3E00, 14'h3C00, 14'h3900, 14'h3800, 14'h3A00, 14'h3400, 14'h0700};
    do_reset();
    for (int i = 0; i < 64; i++) begin
      sel = $urandom_range(0, 11);
      if (sel < 8)       mem[i] = ops[sel] | 14'($urandom_range(0, 255));
      else if (sel < 10) mem[i] = 14'h2000 | 14'($urandom_range(0, 63));
      else if (sel < 11) mem[i] = 14'h2800 | 14'($urandom_range(0, 63));
      else               mem[i] = 14'h0000;
    end
    run = 1;
    for (int i = 0; i < 150; i++) begin
      exec_one();
      model_step();
      checks++;
      if (!got || gap != 3 || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d] ir=%h: got %h want %h", i, mem[fetch_addr], dut_vec(), model_vec());
      end
    end
    run = 0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_flags();
    test_call_ret();
    test_stack_limits();
    test_run_drop();
    test_reset_mid();
    test_pc_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
